// File: rtl/param_ring_counter.sv
// Parametrised ring / Johnson counter with direction, enable, parallel load,
// wrap pulse, illegal-state detection and optional self-correction.
module param_ring_counter #(
  parameter int unsigned           WIDTH        = 4,
  parameter logic [WIDTH-1:0]      INIT         = {1'b1, {(WIDTH-1){1'b0}}},
  parameter bit                    AUTO_CORRECT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             illegal
);

  // Ring legality: exactly one bit set.
  function automatic logic is_ring_legal(input logic [WIDTH-1:0] v);
    int unsigned cnt;
    cnt = 32'd0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt = cnt + 32'(v[i]);
    end
    return (cnt == 32'd1);
  endfunction

  // Johnson legality: at most one boundary between adjacent differing bits.
  function automatic logic is_johnson_legal(input logic [WIDTH-1:0] v);
    logic [WIDTH-2:0] t;
    int unsigned      cnt;
    t   = v[WIDTH-2:0] ^ v[WIDTH-1:1];
    cnt = 32'd0;
    for (int i = 0; i < int'(WIDTH) - 1; i++) begin
      cnt = cnt + 32'(t[i]);
    end
    return (cnt <= 32'd1);
  endfunction

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [WIDTH-1:0] w_home;
  logic [WIDTH-1:0] w_step;
  logic             w_legal;

  // Home state, next step value and legality for the current mode.
  always_comb begin
    w_home  = mode ? {WIDTH{1'b0}} : INIT;
    w_step  = r_q;
    w_legal = mode ? is_johnson_legal(r_q) : is_ring_legal(r_q);
    case ({mode, dir})
      2'b00:   w_step = {r_q[0], r_q[WIDTH-1:1]};
      2'b01:   w_step = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      2'b10:   w_step = {~r_q[0], r_q[WIDTH-1:1]};
      2'b11:   w_step = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
      default: w_step = r_q;
    endcase
  end

  // State update: reset, then load, then correction, then step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q    <= w_home;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_q    <= load_val;
      r_wrap <= 1'b0;
    end else if (en && !w_legal && AUTO_CORRECT) begin
      r_q    <= w_home;
      r_wrap <= 1'b0;
    end else if (en) begin
      r_q    <= w_step;
      r_wrap <= (w_step == w_home);
    end else begin
      r_q    <= r_q;
      r_wrap <= 1'b0;
    end
  end

  assign q       = r_q;
  assign wrap    = r_wrap;
  assign illegal = ~w_legal;

endmodule

// File: tb/tb_param_ring_counter.sv
// Directed self-checking bench for param_ring_counter: default instance,
// a no-correction instance and an 8-bit instance share the control inputs.
module tb_param_ring_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode;
  logic       dir;
  logic       load;
  logic [3:0] load_val;
  logic [7:0] load_val8;

  logic [3:0] q, q_nc;
  logic [7:0] q8;
  logic       wrap, wrap_nc, wrap8;
  logic       illegal, illegal_nc, illegal8;

  int checks;
  int failures;

  param_ring_counter #(.WIDTH(4), .AUTO_CORRECT(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val), .q(q), .wrap(wrap), .illegal(illegal)
  );

  param_ring_counter #(.WIDTH(4), .AUTO_CORRECT(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val), .q(q_nc), .wrap(wrap_nc), .illegal(illegal_nc)
  );

  param_ring_counter #(.WIDTH(8), .AUTO_CORRECT(1'b1)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val8), .q(q8), .wrap(wrap8), .illegal(illegal8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic m, input logic d);
    rst = 1'b0; en = 1'b0; load = 1'b0; mode = m; dir = d;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b0, 1'b0);
    checks++;
    if (q !== 4'b1000 || wrap !== 1'b0 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset q=%b wrap=%b ill=%b exp 1000/0/0", q, wrap, illegal);
    end
    checks++;
    if (q8 !== 8'h80 || wrap8 !== 1'b0) begin
      failures++;
      $display("FAIL reset8 q=%b wrap=%b exp 10000000/0", q8, wrap8);
    end
  endtask

  task automatic test_ring_right();
    logic [3:0] exp_q [0:3];
    exp_q = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    do_reset(1'b0, 1'b0);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (q !== exp_q[i] || wrap !== (i == 3) || illegal !== 1'b0) begin
        failures++;
        $display("FAIL ring_right step%0d q=%b wrap=%b ill=%b exp %b/%0d/0",
                 i, q, wrap, illegal, exp_q[i], (i == 3));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_ring_left_hold();
    logic [3:0] exp_q [0:3];
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset(1'b0, 1'b1);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (q !== exp_q[i] || wrap !== (i == 3)) begin
        failures++;
        $display("FAIL ring_left step%0d q=%b wrap=%b exp %b/%0d",
                 i, q, wrap, exp_q[i], (i == 3));
      end
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== 4'b1000 || wrap !== 1'b0) begin
        failures++;
        $display("FAIL hold cyc%0d q=%b wrap=%b exp 1000/0", i, q, wrap);
      end
    end
  endtask

  task automatic test_johnson(input logic d);
    logic [3:0] exp_r [0:7];
    logic [3:0] exp_l [0:7];
    logic [3:0] e;
    exp_r = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    exp_l = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    do_reset(1'b1, d);
    checks++;
    if (q !== 4'b0000 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL johnson_reset dir=%b q=%b ill=%b exp 0000/0", d, q, illegal);
    end
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      e = d ? exp_l[i] : exp_r[i];
      checks++;
      if (q !== e || wrap !== (i == 7) || illegal !== 1'b0) begin
        failures++;
        $display("FAIL johnson dir=%b step%0d q=%b wrap=%b ill=%b exp %b/%0d/0",
                 d, i, q, wrap, illegal, e, (i == 7));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_load_correct();
    do_reset(1'b0, 1'b0);
    load = 1'b1; load_val = 4'b0110; load_val8 = 8'h80;
    tick();
    load = 1'b0;
    checks++;
    if (q !== 4'b0110 || illegal !== 1'b1 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL load q=%b ill=%b wrap=%b exp 0110/1/0", q, illegal, wrap);
    end
    checks++;
    if (q_nc !== 4'b0110 || illegal_nc !== 1'b1) begin
      failures++;
      $display("FAIL load_nc q=%b ill=%b exp 0110/1", q_nc, illegal_nc);
    end
    en = 1'b1;
    tick();
    en = 1'b0;
    checks++;
    if (q !== 4'b1000 || wrap !== 1'b0 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL correct q=%b wrap=%b ill=%b exp 1000/0/0", q, wrap, illegal);
    end
    checks++;
    if (q_nc !== 4'b0011 || wrap_nc !== 1'b0 || illegal_nc !== 1'b1) begin
      failures++;
      $display("FAIL no_correct q=%b wrap=%b ill=%b exp 0011/0/1", q_nc, wrap_nc, illegal_nc);
    end
  endtask

  task automatic test_reset_midrun();
    do_reset(1'b0, 1'b0);
    en = 1'b1;
    tick();
    tick();
    checks++;
    if (q !== 4'b0010) begin
      failures++;
      $display("FAIL midrun_pre q=%b exp 0010", q);
    end
    rst = 1'b0; load = 1'b1; load_val = 4'b0001;
    tick();
    checks++;
    if (q !== 4'b1000 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_over_load q=%b wrap=%b exp 1000/0", q, wrap);
    end
    rst = 1'b1; load = 1'b0;
    tick();
    en = 1'b0;
    checks++;
    if (q !== 4'b0100 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL resume q=%b wrap=%b exp 0100/0", q, wrap);
    end
  endtask

  task automatic test_mode_switch();
    do_reset(1'b0, 1'b0);
    mode = 1'b1;
    #1;
    checks++;
    if (illegal !== 1'b0) begin
      failures++;
      $display("FAIL switch_1000 ill=%b exp 0", illegal);
    end
    mode = 1'b0;
    en = 1'b1;
    tick();
    en = 1'b0;
    mode = 1'b1;
    #1;
    checks++;
    if (q !== 4'b0100 || illegal !== 1'b1) begin
      failures++;
      $display("FAIL switch_0100 q=%b ill=%b exp 0100/1", q, illegal);
    end
    en = 1'b1;
    tick();
    checks++;
    if (q !== 4'b0000 || wrap !== 1'b0 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL switch_correct q=%b wrap=%b ill=%b exp 0000/0/0", q, wrap, illegal);
    end
    tick();
    en = 1'b0;
    checks++;
    if (q !== 4'b1000 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL switch_step q=%b wrap=%b exp 1000/0", q, wrap);
    end
  endtask

  task automatic test_width8_johnson();
    int wraps;
    wraps = 0;
    do_reset(1'b1, 1'b0);
    checks++;
    if (q8 !== 8'h00) begin
      failures++;
      $display("FAIL w8_reset q=%b exp 00000000", q8);
    end
    en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (wrap8 === 1'b1) wraps++;
      checks++;
      if (wrap8 !== (i == 16) || illegal8 !== 1'b0) begin
        failures++;
        $display("FAIL w8 step%0d wrap=%b ill=%b exp %0d/0", i, wrap8, illegal8, (i == 16));
      end
      if (i == 8) begin
        checks++;
        if (q8 !== 8'hFF) begin
          failures++;
          $display("FAIL w8_half q=%b exp 11111111", q8);
        end
      end
    end
    en = 1'b0;
    checks++;
    if (q8 !== 8'h00 || wraps != 1) begin
      failures++;
      $display("FAIL w8_period q=%b wraps=%0d exp 00000000/1", q8, wraps);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0;
    load_val = 4'b0000; load_val8 = 8'h00;
    test_reset();
    test_ring_right();
    test_ring_left_hold();
    test_johnson(1'b0);
    test_johnson(1'b1);
    test_load_correct();
    test_reset_midrun();
    test_mode_switch();
    test_width8_johnson();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_ring_counter.md
Name: param_ring_counter

Overview:
- Parametrised ring/Johnson counter; next generation of the team's fixed 4-bit one-hot rotator.
- Adds width/seed parameters, runtime mode (ring or Johnson), direction, enable, parallel load, wrap pulse, illegal-state detection and optional self-correction.
- Used as a phase/sequence generator: one-hot strobes or Johnson decode feeding downstream control logic.

Parameters:
- WIDTH, 4, counter width in bits; legal range >= 2.
- INIT, 1 << (WIDTH-1), ring-mode reset and wrap state (4'b1000 at default); must be one-hot.
- AUTO_CORRECT, 1, when 1 an illegal state is replaced by the mode's home state on the next enabled edge; when 0 an illegal state keeps stepping.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- en  input  1  step enable; q advances one position per edge while high.
- mode  input  1  0 = ring (rotate), 1 = Johnson (twisted ring).
- dir  input  1  0 = shift right (toward bit 0), 1 = shift left (toward MSB).
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value loaded into q when load is high.
- q  output  WIDTH  counter state (registered).
- wrap  output  1  registered one-cycle pulse marking completion of a full period.
- illegal  output  1  combinational flag; q is not a legal state for the current mode.

Behaviour:
- Home state H: ring mode H = INIT; Johnson mode H = all zeros.
- Ring step: dir=0 gives q <= {q[0], q[WIDTH-1:1]}; dir=1 gives q <= {q[WIDTH-2:0], q[WIDTH-1]}.
- Johnson step: dir=0 gives q <= {~q[0], q[WIDTH-1:1]}; dir=1 gives q <= {q[WIDTH-2:0], ~q[WIDTH-1]}.
- Legality (combinational, from q and the current mode):
  - Ring: exactly one bit of q set.
  - Johnson: at most one i in 0..WIDTH-2 with q[i] != q[i+1].
  - illegal = !legal.
- Edge priority, highest first:
  1. rst == 0: q <= H for the mode sampled that edge; wrap <= 0. Reset overrides load and en.
  2. load == 1: q <= load_val verbatim, even if illegal; wrap <= 0. Load is independent of en.
  3. en == 1 && illegal && AUTO_CORRECT: q <= H; wrap <= 0.
  4. en == 1: q <= step(q); wrap <= (step(q) == H).
  5. Otherwise q holds and wrap <= 0.
- wrap is high exactly in the cycle q holds H as the result of a step. It is never high after reset, load or correction.
- Period with continuous en: WIDTH steps in ring mode, 2*WIDTH steps in Johnson mode, regardless of dir.
- Latency: one edge from en/load/rst to q; no pipelining.
- Mode change mid-run: H and the legality rule switch immediately (combinational).
  - Ring to Johnson with a one-hot q: q is legal only if it equals 1 at the MSB or LSB end (e.g. 1000 or 0001); otherwise illegal, and correction applies if enabled.
  - Johnson to ring: same rule applies.
- dir change mid-run: takes effect on the next step; no correction triggered.
- After reset with a stable mode, q is always legal. illegal can assert only via load or a mode change.

Test Plan:
- WIDTH=4, mode=0, dir=0: release rst, hold en=1 -> q = 1000, 0100, 0010, 0001, 1000; wrap high only in the cycle of the second 1000; illegal stays 0.
- Ring, dir=1 from reset -> q = 1000, 0001, 0010, 0100, 1000; then en=0 for 3 cycles -> q holds 1000, wrap=0.
- mode=1, dir=0 from reset -> q = 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000; wrap pulses once per 8 steps. Repeat with dir=1 -> 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000.
- Ring mode, load=1, load_val=0110, en=0 -> q=0110 and illegal=1. Then en=1:
  - AUTO_CORRECT=1 -> q=1000, wrap=0, illegal=0.
  - AUTO_CORRECT=0 -> q=0011 (dir=0) and illegal stays 1.
- Reset mid-run: ring at q=0010, drive rst=0 with load=1, load_val=0001 -> next edge q=1000, wrap=0. Release rst -> counting resumes 0100.
- Mode switch at ring q=0100 to mode=1 -> illegal=1 immediately; next enabled edge q=0000 (AUTO_CORRECT=1); WIDTH=8 regression confirms a 16-step Johnson period.
